// File: rtl/user_data_mux.sv
// user_data_mux
//   Write-path data multiplexer that sits behind the per-vFPGA user request
//   arbiter. For every granted request the arbiter pushes one {id, n_tr}
//   sequence entry. This block pops that entry and forwards exactly n_tr+1
//   beats from input stream s_axis[id] to the single output stream. As a
//   result, data on the shared stream leaves in the same order as the grants.
//
// Ports
//   aclk, areset        clock; synchronous active-high reset
//   mux_valid_i/ready_o sequence-entry handshake
//   mux_data_i          sequence entry {id, n_tr}, where n_tr = beats-1
//   s_axis_*_i/_o       N_CPID input streams, flattened with lane i in slice i
//   m_axis_*_o/_i       merged output stream; tlast comes from the beat counter
//   err_last            sticky flag: input tlast disagreed with the counter
//
// Build option
//   USER_MUX_LAST_CHK_EN  When defined, input tlast is compared on every beat
//                         and err_last is driven. When undefined, err_last is 0.
module user_data_mux #(
  parameter int N_CPID        = 2,
  parameter int AXI_DATA_BITS = 512,
  parameter int LEN_BITS      = 28
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  input  logic                                      mux_valid_i,
  output logic                                      mux_ready_o,
  input  logic [((N_CPID > 1) ? $clog2(N_CPID) : 1)
               + (LEN_BITS - $clog2(AXI_DATA_BITS/8)) - 1:0] mux_data_i,
  input  logic [N_CPID*AXI_DATA_BITS-1:0]           s_axis_tdata_i,
  input  logic [N_CPID*(AXI_DATA_BITS/8)-1:0]       s_axis_tkeep_i,
  input  logic [N_CPID-1:0]                         s_axis_tlast_i,
  input  logic [N_CPID-1:0]                         s_axis_tvalid_i,
  output logic [N_CPID-1:0]                         s_axis_tready_o,
  output logic [AXI_DATA_BITS-1:0]                  m_axis_tdata_o,
  output logic [AXI_DATA_BITS/8-1:0]                m_axis_tkeep_o,
  output logic                                      m_axis_tlast_o,
  output logic                                      m_axis_tvalid_o,
  input  logic                                      m_axis_tready_i,
  output logic                                      err_last
);

  localparam int N_CPID_BITS = (N_CPID > 1) ? $clog2(N_CPID) : 1;
  localparam int BLEN_BITS   = LEN_BITS - $clog2(AXI_DATA_BITS/8);
  localparam int KEEP_BITS   = AXI_DATA_BITS/8;

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t                 state_q, state_d;
  logic [N_CPID_BITS-1:0] id_q, id_d;
  logic [BLEN_BITS-1:0]   cnt_q, cnt_d;

  logic [N_CPID_BITS-1:0] mux_id;
  logic [BLEN_BITS-1:0]   mux_ntr;
  logic                   xfer;
  logic                   last_beat;
  logic                   beat_hs;
  logic                   mux_hs;
  logic [N_CPID-1:0]      id_legal;

  logic [AXI_DATA_BITS-1:0] s_tdata_arr [N_CPID];
  logic [KEEP_BITS-1:0]     s_tkeep_arr [N_CPID];
  logic [AXI_DATA_BITS-1:0] sel_tdata;
  logic [KEEP_BITS-1:0]     sel_tkeep;
  logic                     sel_tvalid;

  assign mux_id  = mux_data_i[N_CPID_BITS+BLEN_BITS-1 -: N_CPID_BITS];
  assign mux_ntr = mux_data_i[BLEN_BITS-1:0];

  // All handshake outputs are gated by reset, so nothing moves while areset is high.
  assign xfer      = !areset && (state_q == ST_XFER);
  assign last_beat = (cnt_q == '0);

  genvar gi;
  generate
    for (gi = 0; gi < N_CPID; gi++) begin : g_lane
      assign s_tdata_arr[gi]     = s_axis_tdata_i[gi*AXI_DATA_BITS +: AXI_DATA_BITS];
      assign s_tkeep_arr[gi]     = s_axis_tkeep_i[gi*KEEP_BITS +: KEEP_BITS];
      assign s_axis_tready_o[gi] = xfer && (id_q == N_CPID_BITS'(gi)) && m_axis_tready_i;
      assign id_legal[gi]        = (mux_id == N_CPID_BITS'(gi));
    end
  endgenerate

  // Select the active lane. An id outside the lane range matches nothing,
  // so the output reads as zeros with tvalid low.
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    for (int i = 0; i < N_CPID; i++) begin
      if (id_q == N_CPID_BITS'(i)) begin
        sel_tdata  = s_tdata_arr[i];
        sel_tkeep  = s_tkeep_arr[i];
        sel_tvalid = s_axis_tvalid_i[i];
      end
    end
  end

  assign m_axis_tdata_o  = sel_tdata;
  assign m_axis_tkeep_o  = sel_tkeep;
  assign m_axis_tvalid_o = xfer && sel_tvalid;
  assign m_axis_tlast_o  = xfer && last_beat;

  assign beat_hs = m_axis_tvalid_o && m_axis_tready_i;

  // The next entry is accepted on the last beat itself, so consecutive bursts
  // run back to back without an idle cycle between them.
  assign mux_ready_o = !areset && ((state_q == ST_IDLE) || (xfer && beat_hs && last_beat));
  assign mux_hs      = mux_valid_i && mux_ready_o;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mux_hs) begin
          id_d    = mux_id;
          cnt_d   = mux_ntr;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat_hs) begin
          if (!last_beat) begin
            cnt_d = cnt_q - BLEN_BITS'(1);
          end else if (mux_hs) begin
            id_d  = mux_id;
            cnt_d = mux_ntr;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entries whose id names a lane that does not exist are illegal.
  always @(posedge aclk) begin
    if (!areset && mux_hs) begin
      assert (|id_legal);
    end
  end

`ifdef USER_MUX_LAST_CHK_EN
  logic sel_tlast;
  logic err_last_q;

  always_comb begin
    sel_tlast = 1'b0;
    for (int i = 0; i < N_CPID; i++) begin
      if (id_q == N_CPID_BITS'(i)) begin
        sel_tlast = s_axis_tlast_i[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_last_q <= 1'b0;
    end else if (beat_hs && (sel_tlast != last_beat)) begin
      err_last_q <= 1'b1;
    end
  end

  assign err_last = err_last_q;
`else
  // Input tlast is not needed on the data path when the check is disabled.
  logic tlast_unused;
  assign tlast_unused = ^s_axis_tlast_i;
  assign err_last     = 1'b0;
`endif

endmodule

// File: tb/tb_user_data_mux.sv
// Scoreboard bench for user_data_mux.
//   The stimulus thread pushes three things: mux entries, per-lane source
//   beats, and expected output beats. A driver process feeds the DUT from
//   these queues. A monitor process compares every valid output cycle with
//   the head of the expected queue.
module tb_user_data_mux;

  localparam int N_CPID   = 2;
  localparam int DW       = 32;
  localparam int KB       = DW/8;
  localparam int LEN_BITS = 5;
  localparam int BLEN     = 3;
  localparam logic [DW-1:0] SENT = 32'hDEAD_BEEF;

  logic                 aclk = 1'b0;
  logic                 areset = 1'b1;
  logic                 mux_valid = 1'b0;
  logic                 mux_ready;
  logic [BLEN:0]        mux_data = '0;
  logic [N_CPID*DW-1:0] s_tdata = '0;
  logic [N_CPID*KB-1:0] s_tkeep = '0;
  logic [N_CPID-1:0]    s_tlast = '0;
  logic [N_CPID-1:0]    s_tvalid = '0;
  logic [N_CPID-1:0]    s_tready;
  logic [DW-1:0]        m_tdata;
  logic [KB-1:0]        m_tkeep;
  logic                 m_tlast;
  logic                 m_tvalid;
  logic                 m_tready = 1'b0;
  logic                 err_last;

  user_data_mux #(.N_CPID(N_CPID), .AXI_DATA_BITS(DW), .LEN_BITS(LEN_BITS)) dut (
    .aclk(aclk), .areset(areset),
    .mux_valid_i(mux_valid), .mux_ready_o(mux_ready), .mux_data_i(mux_data),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tlast_i(s_tlast),
    .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tlast_o(m_tlast),
    .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .err_last(err_last)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] data; logic [KB-1:0] keep; logic last; int gap; } src_t;
  typedef struct { int id; logic [DW-1:0] data; logic [KB-1:0] keep; logic last; } exp_t;

  src_t        src0[$];
  src_t        src1[$];
  exp_t        exp_q[$];
  logic [BLEN:0] mux_q[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          g0 = 0;
  int          g1 = 0;
  int          rdy_mode = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Driver: apply queue heads 1 time unit after each edge and pop after handshakes.
  initial begin : driver
    bit hs0, hs1, mhs;
    forever begin
      @(negedge aclk);
      hs0 = s_tvalid[0] & s_tready[0];
      hs1 = s_tvalid[1] & s_tready[1];
      mhs = mux_valid & mux_ready;
      @(posedge aclk);
      #1;
      if (hs0 && src0.size() > 0) begin void'(src0.pop_front()); g0 = 0; end
      if (hs1 && src1.size() > 0) begin void'(src1.pop_front()); g1 = 0; end
      if (mhs && mux_q.size() > 0) void'(mux_q.pop_front());
      if (src0.size() > 0 && g0 >= src0[0].gap) begin
        s_tvalid[0] = 1'b1; s_tdata[DW-1:0] = src0[0].data;
        s_tkeep[KB-1:0] = src0[0].keep; s_tlast[0] = src0[0].last;
      end else begin
        s_tvalid[0] = 1'b0; s_tdata[DW-1:0] = SENT; s_tkeep[KB-1:0] = '0; s_tlast[0] = 1'b0;
        if (src0.size() > 0) g0++;
      end
      if (src1.size() > 0 && g1 >= src1[0].gap) begin
        s_tvalid[1] = 1'b1; s_tdata[2*DW-1:DW] = src1[0].data;
        s_tkeep[2*KB-1:KB] = src1[0].keep; s_tlast[1] = src1[0].last;
      end else begin
        s_tvalid[1] = 1'b0; s_tdata[2*DW-1:DW] = SENT; s_tkeep[2*KB-1:KB] = '0; s_tlast[1] = 1'b0;
        if (src1.size() > 0) g1++;
      end
      mux_valid = (mux_q.size() > 0);
      mux_data  = (mux_q.size() > 0) ? mux_q[0] : '0;
      m_tready  = (rdy_mode == 0) ? 1'b1 : ~m_tready;
    end
  end

  // Monitor: check reset gating, and check every presented output beat against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_mux_ready", mux_ready, 0);
      end else if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_valid: got m_tvalid=1 data=0x%0h, expected no beat (cycle %0d)", m_tdata, cyc);
        end else begin
          e = exp_q[0];
          check("tdata", m_tdata, e.data);
          check("tkeep", m_tkeep, e.keep);
          if (m_tready) begin
            check("tlast", m_tlast, e.last);
            check("sel_tready", s_tready, (e.id == 0) ? 2'b01 : 2'b10);
            check("mux_ready_on_beat", mux_ready, e.last);
            $display("beat id=%0d data=0x%08h keep=0x%0h last=%0b cycle=%0d", e.id, m_tdata, m_tkeep, m_tlast, cyc);
            hs_cyc.push_back(cyc);
            void'(exp_q.pop_front());
          end else begin
            check("stall_tready", s_tready, 0);
          end
        end
      end
    end
  end

  // Queue one burst: the mux entry, nsup source beats, and all ntr+1 expected beats.
  task automatic burst(input int id, input int ntr, input logic [DW-1:0] base,
                       input int gap, input int nsup, input bit bad_last);
    src_t s;
    exp_t e;
    mux_q.push_back({1'(id), 3'(ntr)});
    for (int i = 0; i <= ntr; i++) begin
      s.data = base + DW'(i);
      s.keep = (i == ntr) ? 4'h3 : 4'hF;
      s.last = (i == ntr) ^ (bad_last && i == 0);
      s.gap  = (i > 0) ? gap : 0;
      if (i < nsup) begin
        if (id == 0) src0.push_back(s); else src1.push_back(s);
      end
      e.id = id; e.data = s.data; e.keep = s.keep; e.last = (i == ntr);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 || mux_q.size() != 0) begin
      @(posedge aclk); #3;
      n++;
      if (n > budget) begin
        n_checks++; n_fail++;
        $display("FAIL %s_timeout: got %0d beats pending after %0d cycles, expected 0", name, exp_q.size(), budget);
        exp_q.delete(); mux_q.delete(); src0.delete(); src1.delete();
        return;
      end
    end
  endtask

  task automatic check_span(input string name, input int nbeats, input int span);
    check({name, "_count"}, hs_cyc.size(), nbeats);
    if (hs_cyc.size() > 0) check({name, "_span"}, hs_cyc[hs_cyc.size()-1] - hs_cyc[0], span);
  endtask

  task automatic check_idle(input string name);
    @(negedge aclk);
    check({name, "_tvalid"}, m_tvalid, 0);
    check({name, "_mux_ready"}, mux_ready, 1);
  endtask

  initial begin : test
    int n;
    repeat (3) @(posedge aclk);
    #2 areset = 1'b0;
    @(negedge aclk);
    check("post_rst_tvalid", m_tvalid, 0);
    check("post_rst_mux_ready", mux_ready, 1);
    check("post_rst_s_tready", s_tready, 0);
    check("post_rst_err_last", err_last, 0);

    // Single 4-beat burst from lane 1.
    @(posedge aclk); #2; hs_cyc.delete();
    burst(1, 3, 32'h1000_0000, 0, 4, 1'b0);
    wait_drain("t1", 50);
    check_span("t1", 4, 3);
    check_idle("t1_idle");

    // Two entries queued back to back, with no bubble between bursts.
    @(posedge aclk); #2; hs_cyc.delete();
    burst(0, 1, 32'hA000_0000, 0, 2, 1'b0);
    burst(1, 0, 32'hB000_0000, 0, 1, 1'b0);
    wait_drain("t2", 50);
    check_span("t2", 3, 2);

    // Single beat while m_tready toggles.
    @(posedge aclk); #2; hs_cyc.delete(); rdy_mode = 1;
    burst(0, 0, 32'hC000_0000, 0, 1, 1'b0);
    wait_drain("t3", 50);
    check_span("t3", 1, 0);
    check_idle("t3_idle");
    @(posedge aclk); #2; rdy_mode = 0;

    // Source gaps of 2 cycles in the middle of a burst.
    @(posedge aclk); #2; hs_cyc.delete();
    burst(0, 2, 32'hD000_0000, 2, 3, 1'b0);
    wait_drain("t4", 50);
    check_span("t4", 3, 6);

    // Reset after 2 of 4 beats.
    @(posedge aclk); #2; hs_cyc.delete();
    burst(1, 3, 32'hE000_0000, 0, 2, 1'b0);
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin @(posedge aclk); #2; n++; end
    check("t5_beats_before_rst", exp_q.size(), 2);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #2;
    exp_q.delete(); mux_q.delete(); src0.delete(); src1.delete(); g0 = 0; g1 = 0;
    areset = 1'b0;
    check_idle("t5_idle");
    @(posedge aclk); #2; hs_cyc.delete();
    burst(1, 0, 32'hE100_0000, 0, 1, 1'b0);
    wait_drain("t5", 50);
    check_span("t5", 1, 0);

    // Maximum burst length: 8 beats.
    @(posedge aclk); #2; hs_cyc.delete();
    burst(1, 7, 32'hF000_0000, 0, 8, 1'b0);
    wait_drain("t6", 50);
    check_span("t6", 8, 7);

    // Input tlast on the wrong beat. The output tlast still comes from the counter.
    @(posedge aclk); #2; hs_cyc.delete();
    burst(0, 1, 32'h5000_0000, 0, 2, 1'b1);
    wait_drain("t7", 50);
    @(negedge aclk);
`ifdef USER_MUX_LAST_CHK_EN
    check("t7_err_last", err_last, 1);
    repeat (3) @(negedge aclk);
    check("t7_err_sticky", err_last, 1);
`else
    check("t7_err_last", err_last, 0);
    repeat (3) @(negedge aclk);
    check("t7_err_sticky", err_last, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
